// File: rtl/keypad_pkg.sv
// Shared types for the keypad scanner: FSM state encoding and default key-code width.
package keypad_pkg;
  typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} scan_state_t;
  localparam int KEY_W = $clog2(4 * 4);
endpackage

// File: rtl/scan_tick_gen.sv
// Free-running scan divider: tick on the last count, row sample strobe one cycle earlier
// so the row flip-flops are loaded just before the FSM evaluates them.
module scan_tick_gen #(
  parameter int SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic reset,
  output logic tick,
  output logic smp_en
);
  localparam int CW = $clog2(SCAN_DIV);

  logic [CW-1:0] count;

  assign tick   = (count == CW'(SCAN_DIV - 1));
  assign smp_en = (count == CW'(SCAN_DIV - 2));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)     count <= '0;
    else if (tick) count <= '0;
    else           count <= count + 1'b1;
  end
endmodule

// File: rtl/keypad_scan_ctrl.sv
// Matrix keypad scanner: rotates the column drive, debounces press/release of the
// lowest-index active row and emits one encoded key event per accepted press.
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int N_ROWS         = 4,
  parameter int N_COLS         = 4,
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [N_ROWS-1:0]                 row_q,
  output logic [N_COLS-1:0]                 col_drv,
  output logic                              row_smp_en,
  output logic [$clog2(N_ROWS*N_COLS)-1:0]  key_code,
  output logic                              key_valid,
  output logic                              key_held
);
  localparam int KW  = $clog2(N_ROWS * N_COLS);
  localparam int RW  = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CLW = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int DW  = $clog2(DEBOUNCE_TICKS + 1);

  scan_state_t     state;
  logic            tick;
  logic [RW-1:0]   hit_row;
  logic [RW-1:0]   lat_row;
  logic [CLW-1:0]  col_idx;
  logic [CLW-1:0]  col_idx_nxt;
  logic [N_COLS-1:0] col_drv_nxt;
  logic [DW-1:0]   cnt;
  logic            row_bit;

  scan_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk    (clk),
    .reset  (reset),
    .tick   (tick),
    .smp_en (row_smp_en)
  );

  // Lowest-index row wins when several are active.
  always_comb begin
    hit_row = '0;
    for (int i = N_ROWS - 1; i >= 0; i--)
      if (row_q[i]) hit_row = RW'(i);
  end

  assign row_bit     = row_q[lat_row];
  assign col_drv_nxt = {col_drv[N_COLS-2:0], col_drv[N_COLS-1]};
  assign col_idx_nxt = (col_idx == CLW'(N_COLS - 1)) ? '0 : col_idx + 1'b1;

  // The counter stops at DEBOUNCE_TICKS; acceptance happens on the tick after it gets there.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SCAN;
      col_drv   <= N_COLS'(1);
      col_idx   <= '0;
      lat_row   <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (tick) begin
        case (state)
          SCAN: begin
            if (row_q == '0) begin
              col_drv <= col_drv_nxt;
              col_idx <= col_idx_nxt;
            end else begin
              lat_row <= hit_row;
              cnt     <= '0;
              state   <= DEB_PRESS;
            end
          end
          DEB_PRESS: begin
            if (!row_bit) begin
              col_drv <= col_drv_nxt;
              col_idx <= col_idx_nxt;
              state   <= SCAN;
            end else if (cnt == DW'(DEBOUNCE_TICKS)) begin
              key_code  <= KW'(lat_row) * KW'(N_COLS) + KW'(col_idx);
              key_valid <= 1'b1;
              key_held  <= 1'b1;
              state     <= HELD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          HELD: begin
            if (!row_bit) begin
              cnt   <= '0;
              state <= DEB_REL;
            end
          end
          DEB_REL: begin
            if (row_bit) begin
              state <= HELD;
            end else if (cnt == DW'(DEBOUNCE_TICKS)) begin
              key_held <= 1'b0;
              col_drv  <= col_drv_nxt;
              col_idx  <= col_idx_nxt;
              state    <= SCAN;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= SCAN;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Directed bench for keypad_scan_ctrl at SCAN_DIV=4, DEBOUNCE_TICKS=3, 4x4 geometry.
module tb_keypad_scan_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] row_q;
  logic [3:0] col_drv;
  logic       row_smp_en;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  int errors = 0;
  int checks = 0;
  int kv_cycles = 0;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] col;
    logic       v;
    logic       h;
    logic [3:0] code;
  } vec_t;

  vec_t tbl [33];

  keypad_scan_ctrl #(
    .N_ROWS(4), .N_COLS(4), .SCAN_DIV(4), .DEBOUNCE_TICKS(3)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .row_q      (row_q),
    .col_drv    (col_drv),
    .row_smp_en (row_smp_en),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (key_valid) kv_cycles++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present rv to the rows and return at the negedge just after the next tick edge.
  task automatic next_tick(input logic [3:0] rv);
    int n;
    row_q = rv;
    n = 0;
    @(negedge clk);
    while (!row_smp_en && n < 8) begin
      @(negedge clk);
      n++;
    end
    if (!row_smp_en) begin
      checks++;
      errors++;
      $display("FAIL tick_sync: row_smp_en %0b expected 1 within 8 cycles", row_smp_en);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_col"},  32'(col_drv),    32'h1);
    chk({tag, "_smp"},  32'(row_smp_en), 32'h0);
    chk({tag, "_code"}, 32'(key_code),   32'h0);
    chk({tag, "_v"},    32'(key_valid),  32'h0);
    chk({tag, "_h"},    32'(key_held),   32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1);
  end

  initial begin
    // glitch at col 1: high 2 ticks, then low
    tbl[0]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[1]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[2]  = '{4'b0000, 4'b0100, 1'b0, 1'b0, 4'd0};
    // idle back round to col 1
    tbl[3]  = '{4'b0000, 4'b1000, 1'b0, 1'b0, 4'd0};
    tbl[4]  = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'd0};
    tbl[5]  = '{4'b0000, 4'b0010, 1'b0, 1'b0, 4'd0};
    // row 2 press at col 1 -> code 9 on the 5th high tick
    tbl[6]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[7]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[8]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[9]  = '{4'b0100, 4'b0010, 1'b0, 1'b0, 4'd0};
    tbl[10] = '{4'b0100, 4'b0010, 1'b1, 1'b1, 4'd9};
    tbl[11] = '{4'b0100, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[12] = '{4'b0110, 4'b0010, 1'b0, 1'b1, 4'd9};
    // release bounce: low 1, high 1, then low until released
    tbl[13] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[14] = '{4'b0100, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[15] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[16] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[17] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[18] = '{4'b0000, 4'b0010, 1'b0, 1'b1, 4'd9};
    tbl[19] = '{4'b0000, 4'b0100, 1'b0, 1'b0, 4'd9};
    // rows 1 and 3 together at col 3 -> code 7; dropping row 3 keeps it held
    tbl[20] = '{4'b0000, 4'b1000, 1'b0, 1'b0, 4'd9};
    tbl[21] = '{4'b1010, 4'b1000, 1'b0, 1'b0, 4'd9};
    tbl[22] = '{4'b1010, 4'b1000, 1'b0, 1'b0, 4'd9};
    tbl[23] = '{4'b1010, 4'b1000, 1'b0, 1'b0, 4'd9};
    tbl[24] = '{4'b1010, 4'b1000, 1'b0, 1'b0, 4'd9};
    tbl[25] = '{4'b1010, 4'b1000, 1'b1, 1'b1, 4'd7};
    tbl[26] = '{4'b0010, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[27] = '{4'b0010, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[28] = '{4'b0000, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[29] = '{4'b0000, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[30] = '{4'b0000, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[31] = '{4'b0000, 4'b1000, 1'b0, 1'b1, 4'd7};
    tbl[32] = '{4'b0000, 4'b0001, 1'b0, 1'b0, 4'd7};

    reset = 1'b1;
    row_q = 4'b0000;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");

    // idle scan: column steps every 4 cycles, strobe at count 2
    reset = 1'b0;
    for (int k = 0; k < 20; k++) begin
      logic [3:0] ec;
      #1;
      ec = 4'b0001 << ((k / 4) % 4);
      chk($sformatf("idle%0d_col", k), 32'(col_drv), 32'(ec));
      chk($sformatf("idle%0d_smp", k), 32'(row_smp_en), 32'((k % 4) == 2));
      @(negedge clk);
    end
    chk("idle_no_valid", 32'(kv_cycles), 32'd0);

    for (int i = 0; i < 33; i++) begin
      next_tick(tbl[i].rq);
      chk($sformatf("vec%0d_col", i),  32'(col_drv),   32'(tbl[i].col));
      chk($sformatf("vec%0d_v", i),    32'(key_valid), 32'(tbl[i].v));
      chk($sformatf("vec%0d_h", i),    32'(key_held),  32'(tbl[i].h));
      chk($sformatf("vec%0d_code", i), 32'(key_code),  32'(tbl[i].code));
    end
    @(negedge clk);
    chk("table_valid_cycles", 32'(kv_cycles), 32'd2);

    // reset in the middle of a press debounce
    next_tick(4'b0001);
    next_tick(4'b0001);
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_deb");
    @(negedge clk);
    reset = 1'b0;

    // fresh press of row 3 at col 0 needs a full debounce again
    for (int j = 0; j < 4; j++) begin
      next_tick(4'b1000);
      chk($sformatf("post_rst%0d_v", j), 32'(key_valid), 32'd0);
      chk($sformatf("post_rst%0d_h", j), 32'(key_held),  32'd0);
    end
    next_tick(4'b1000);
    chk("post_rst_accept_v",    32'(key_valid), 32'd1);
    chk("post_rst_accept_code", 32'(key_code),  32'd12);
    chk("post_rst_accept_col",  32'(col_drv),   32'h1);
    next_tick(4'b1000);
    chk("post_rst_held", 32'(key_held), 32'd1);

    // reset while held
    #2 reset = 1'b1;
    #1 chk_reset_vals("rst_held");
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 6; j++) next_tick(4'b0000);
    chk("final_held",         32'(key_held),  32'd0);
    chk("final_valid_cycles", 32'(kv_cycles), 32'd3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
